add_cla_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; the next generation of the fixed-width 8-bit CLA adder.
- Splits a WIDTH-bit operation into STAGES = WIDTH/SEG segments of SEG bits each. Each segment is a SEG-bit CLA, one segment per pipeline stage, with the carry registered between stages.
- Adds a per-transaction add/sub mode, a signed-overflow flag, and a valid/ready handshake with backpressure.
- Used as the mantissa/exponent adder in the FP datapath wherever timing needs a wide adder to be pipelined.

---
 rtl/add_cla_pipe_if.sv | 27 ++
 rtl/add_cla_pipe.sv | 159 +++++++++++++++
 tb/tb_add_cla_pipe.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_cla_pipe_if.sv
// Handshake and operand/result bundle for the pipelined CLA adder/subtractor.
// The master side issues operands and consumes results; the slave side is the adder.
interface add_cla_pipe_if #(
    parameter int WIDTH = 32
);
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iC;
    logic             iSub;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oS;
    logic             oC;
    logic             oV;

    modport master (
        output iValid, iA, iB, iC, iSub, iReady,
        input  oReady, oValid, oS, oC, oV
    );

    modport slave (
        input  iValid, iA, iB, iC, iSub, iReady,
        output oReady, oValid, oS, oC, oV
    );
endinterface

// File: rtl/add_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit CLA segment per stage,
// carry registered between stages, operands skewed in and sums deskewed out.
module add_cla_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic          iClk,
    input logic          iRst,
    add_cla_pipe_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;
    localparam int NGRP   = SEG / 4;

    // SEG-bit CLA built from 4-bit groups; returns {carry_out, sum}.
    function automatic logic [SEG:0] cla_seg(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  g;
        logic [SEG:0]    c;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP:0]   gc;
        p  = a ^ b;
        g  = a & b;
        c  = {(SEG+1){1'b0}};
        gg = {NGRP{1'b0}};
        gp = {NGRP{1'b1}};
        gc = {(NGRP+1){1'b0}};
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < 4; i++) begin
                gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
                gp[j] = gp[j] & p[4*j+i];
            end
        end
        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[SEG] = gc[NGRP];
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic             en_s;
    logic [WIDTH-1:0] be_s;
    logic             cin_s;

    // Subtraction is A + ~B + ~borrow; the mode only shapes what enters the pipe.
    assign be_s  = bus.iSub ? ~bus.iB : bus.iB;
    assign cin_s = bus.iSub ? ~bus.iC : bus.iC;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SUMW = (k + 1) * SEG;

        logic [SEG-1:0]  seg_a_s;
        logic [SEG-1:0]  seg_b_s;
        logic            seg_cin_s;
        logic            valid_in_s;
        logic [SEG:0]    res_s;
        logic [SUMW-1:0] sum_d;
        logic [SUMW-1:0] sum_q;
        logic            c_d;
        logic            c_q;
        logic            valid_d;
        logic            valid_q;

        if (k == 0) begin : g_head
            assign seg_a_s    = bus.iA[SEG-1:0];
            assign seg_b_s    = be_s[SEG-1:0];
            assign seg_cin_s  = cin_s;
            assign valid_in_s = bus.iValid;
            assign sum_d      = res_s[SEG-1:0];
        end else begin : g_body
            assign seg_a_s    = g_stage[k-1].g_fwd.a_q[SEG-1:0];
            assign seg_b_s    = g_stage[k-1].g_fwd.b_q[SEG-1:0];
            assign seg_cin_s  = g_stage[k-1].c_q;
            assign valid_in_s = g_stage[k-1].valid_q;
            assign sum_d      = {res_s[SEG-1:0], g_stage[k-1].sum_q};
        end

        assign res_s   = cla_seg(seg_a_s, seg_b_s, seg_cin_s);
        assign c_d     = res_s[SEG];
        assign valid_d = valid_in_s;

        // Stage register: segment sum, carry out and valid advance together.
        always_ff @(posedge iClk) begin
            if (iRst) begin
                valid_q <= 1'b0;
                c_q     <= 1'b0;
                sum_q   <= {SUMW{1'b0}};
            end else if (en_s) begin
                valid_q <= valid_d;
                c_q     <= c_d;
                sum_q   <= sum_d;
            end
        end

        // Not-yet-added operand bits, shifted so the next segment sits at bit 0.
        if (k < STAGES - 1) begin : g_fwd
            localparam int REMW = WIDTH - SUMW;
            logic [REMW-1:0] a_d;
            logic [REMW-1:0] b_d;
            logic [REMW-1:0] a_q;
            logic [REMW-1:0] b_q;

            if (k == 0) begin : g_src_in
                assign a_d = bus.iA[WIDTH-1:SEG];
                assign b_d = be_s[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign a_d = g_stage[k-1].g_fwd.a_q[REMW+SEG-1:SEG];
                assign b_d = g_stage[k-1].g_fwd.b_q[REMW+SEG-1:SEG];
            end

            // Operand skew register.
            always_ff @(posedge iClk) begin
                if (iRst) begin
                    a_q <= {REMW{1'b0}};
                    b_q <= {REMW{1'b0}};
                end else if (en_s) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // Carry into the MSB equals a^b^sum at that bit, so overflow needs no extra tap.
        if (k == STAGES - 1) begin : g_last
            logic v_d;
            logic v_q;

            assign v_d = seg_a_s[SEG-1] ^ seg_b_s[SEG-1] ^ res_s[SEG-1] ^ res_s[SEG];

            // Signed-overflow flag register.
            always_ff @(posedge iClk) begin
                if (iRst) begin
                    v_q <= 1'b0;
                end else if (en_s) begin
                    v_q <= v_d;
                end
            end
        end
    end

    // Whole pipe stalls as one when the result is held by the consumer.
    assign en_s       = ~g_stage[STAGES-1].valid_q | bus.iReady;
    assign bus.oReady = en_s;
    assign bus.oValid = g_stage[STAGES-1].valid_q;
    assign bus.oS     = g_stage[STAGES-1].sum_q;
    assign bus.oC     = g_stage[STAGES-1].c_q;
    assign bus.oV     = g_stage[STAGES-1].g_last.v_q;
endmodule

// File: tb/tb_add_cla_pipe.sv
// Scoreboard bench for add_cla_pipe: stimulus pushes expected results computed with
// plain integer arithmetic, a monitor pops and compares on every output handshake.
module tb_add_cla_pipe;
    localparam int W   = 32;
    localparam int SEG = 8;
    localparam int ST  = W / SEG;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic [31:0]  cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_mode = 0;
    bit          lat_exact = 1'b1;
    exp_t        sb_q[$];
    logic [W+1:0] held;
    bit          holding = 1'b0;

    add_cla_pipe_if #(.WIDTH(W)) bus ();

    add_cla_pipe #(.WIDTH(W), .SEG(SEG)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: integer add/subtract with borrow, overflow from the true signed result.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sub);
        exp_t            e;
        longint unsigned ua, ub, cu, u;
        longint          sa, sb, r;
        ua = {32'd0, a};
        ub = {32'd0, b};
        cu = {63'd0, c};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u   = ua - ub - cu;
            e.c = (ua >= ub + cu);
            r   = sa - sb - longint'(cu);
        end else begin
            u   = ua + ub + cu;
            e.c = u[32];
            r   = sa + sb + longint'(cu);
        end
        e.s   = u[31:0];
        e.v   = (r > SMAX) || (r < SMIN);
        e.cyc = 32'd0;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] x;
        case ($urandom_range(0, 5))
            0:       x = 32'h0000_0000;
            1:       x = 32'hFFFF_FFFF;
            2:       x = 32'h8000_0000;
            3:       x = 32'h7FFF_FFFF;
            default: x = $urandom;
        endcase
        return x;
    endfunction

    // Downstream ready: 0 = always, 1 = never, other = random.
    always @(negedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.iReady = 1'b1;
            1:       bus.iReady = 1'b0;
            default: bus.iReady = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: compare on each output transfer, check hold while stalled.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            sb_q.delete();
            holding = 1'b0;
        end else if (bus.oValid) begin
            if (holding) chk("stall_hold", {bus.oS, bus.oC, bus.oV}, held);
            if (bus.iReady) begin
                holding = 1'b0;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got oS=0x%0h, want no output (cycle %0d)", bus.oS, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("oS", bus.oS, e.s);
                    chk("oC", bus.oC, e.c);
                    chk("oV", bus.oV, e.v);
                    if (lat_exact) chk("latency", cyc, e.cyc);
                    else           chk("latency_min", cyc >= e.cyc, 1);
                end
            end else begin
                held    = {bus.oS, bus.oC, bus.oV};
                holding = 1'b1;
            end
        end else begin
            holding = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic sub, output int unsigned tgt);
        exp_t e;
        tgt = 0;
        @(negedge clk);
        #1;
        bus.iValid = 1'b1;
        bus.iA     = a;
        bus.iB     = b;
        bus.iC     = c;
        bus.iSub   = sub;
        for (int t = 0; t < 200; t++) begin
            #3;
            if (bus.oReady) begin
                e     = model(a, b, c, sub);
                e.cyc = cyc + ST;
                tgt   = e.cyc;
                sb_q.push_back(e);
                @(posedge clk);
                break;
            end
            @(negedge clk);
            #1;
        end
        #1;
        bus.iValid = 1'b0;
        if (tgt == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no oReady, want acceptance within 200 cycles");
        end
    endtask

    task automatic expect_valid_at(input int unsigned target, input logic val, input string name);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            #2;
            if (cyc >= target) break;
        end
        chk({name, "_cycle"}, cyc, target);
        chk(name, bus.oValid, val);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        repeat (2) @(negedge clk);
        chk(name, sb_q.size(), 0);
    endtask

    int unsigned t0, t1, t2, t3;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.iValid = 1'b0;
        bus.iA     = 32'h0;
        bus.iB     = 32'h0;
        bus.iC     = 1'b0;
        bus.iSub   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oValid", bus.oValid, 0);
        chk("rst_oS", bus.oS, 0);
        chk("rst_oC", bus.oC, 0);
        chk("rst_oV", bus.oV, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rst_oReady", bus.oReady, 1);

        // Full carry ripple; result valid for exactly one cycle.
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, t0);
        expect_valid_at(t0 - 1, 1'b0, "ripple_early");
        expect_valid_at(t0, 1'b1, "ripple_valid");
        expect_valid_at(t0 + 1, 1'b0, "ripple_once");

        // Subtraction overflow then plain borrow.
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1, t0);
        send(32'h0, 32'h1, 1'b0, 1'b1, t1);
        expect_valid_at(t1, 1'b1, "sub_valid");

        // Back-to-back mixed mode.
        send(32'd1, 32'd2, 1'b0, 1'b0, t0);
        send(32'd5, 32'd3, 1'b0, 1'b1, t1);
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, t2);
        send(32'd10, 32'd1, 1'b1, 1'b1, t3);
        chk("b2b_spacing", t3 - t0, 3);
        expect_valid_at(t0, 1'b1, "b2b_0");
        expect_valid_at(t1, 1'b1, "b2b_1");
        expect_valid_at(t2, 1'b1, "b2b_2");
        expect_valid_at(t3, 1'b1, "b2b_3");
        drain("b2b_drain");

        // Backpressure: stall from the first result for 5 cycles.
        lat_exact = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(32'(i * 1000 + 7), 32'(i * 13 + 1), i[0], i[1], t0);
                end
            end
            begin
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (bus.oValid) break;
                end
                ready_mode = 1;
                #3;
                chk("bp_oReady_low", bus.oReady, 0);
                repeat (5) @(negedge clk);
                ready_mode = 0;
            end
        join
        drain("bp_drain");
        lat_exact = 1'b1;

        // Bubble between two transactions is preserved.
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, t0);
        @(negedge clk);
        send(32'hDEAD_BEEF, 32'h0000_FFFF, 1'b1, 1'b1, t1);
        expect_valid_at(t0, 1'b1, "bubble_v0");
        expect_valid_at(t0 + 1, 1'b0, "bubble_gap");
        expect_valid_at(t0 + 2, 1'b1, "bubble_v1");
        drain("bubble_drain");

        // Reset with three transactions in flight.
        send(32'd100, 32'd1, 1'b0, 1'b0, t0);
        send(32'd200, 32'd2, 1'b0, 1'b1, t1);
        send(32'd300, 32'd3, 1'b1, 1'b0, t2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_oValid", bus.oValid, 0);
        chk("mrst_oS", bus.oS, 0);
        chk("mrst_oC", bus.oC, 0);
        chk("mrst_oV", bus.oV, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("mrst_oReady", bus.oReady, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("mrst_no_stale", bus.oValid, 0);
        end
        send(32'hCAFE_0000, 32'h0000_BABE, 1'b0, 1'b0, t0);
        expect_valid_at(t0, 1'b1, "mrst_new");
        drain("mrst_drain");

        // Randomized traffic with random backpressure and bubbles.
        lat_exact  = 1'b0;
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t0);
        end
        ready_mode = 0;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
